// File: rtl/player_pkg.sv
// player_pkg: shared types and screen constants for the player motion logic.
package player_pkg;

    typedef enum logic [1:0] {GROUND, RISE, FALL} state_t;

    localparam int POS_W    = 10;
    localparam int VEL_W    = 5;
    localparam int X_MIN    = 0;
    localparam int X_MAX    = 600;
    localparam int Y_GROUND = 400;

endpackage

// File: rtl/player_motion_ctrl_if.sv
// player_motion_ctrl_if: button inputs and sprite position outputs of the motion controller.
interface player_motion_ctrl_if import player_pkg::*; ();

    logic             enable;
    logic             right_n;
    logic             left_n;
    logic             jump_n;
    logic [POS_W-1:0] pos_x;
    logic [POS_W-1:0] pos_y;
    logic             jumping;
    logic             move_tick;

    modport master (
        output enable, right_n, left_n, jump_n,
        input  pos_x, pos_y, jumping, move_tick
    );

    modport slave (
        input  enable, right_n, left_n, jump_n,
        output pos_x, pos_y, jumping, move_tick
    );

endinterface

// File: rtl/player_motion_ctrl_move_tick_gen.sv
// move_tick_gen: frame-rate tick divider; the count freezes while enable_i is low.
module move_tick_gen #(
    parameter int TICK_DIV = 416667
) (
    input  logic clk,
    input  logic rst,
    input  logic enable_i,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] count_q, count_d;

    assign tick_o  = enable_i && (count_q == CW'(TICK_DIV - 1));
    assign count_d = tick_o ? '0 : enable_i ? count_q + CW'(1) : count_q;

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

endmodule

// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: button synchronizers, clamped horizontal steps and jump FSM
// driving the authoritative player sprite position.
module player_motion_ctrl
    import player_pkg::state_t, player_pkg::GROUND, player_pkg::RISE, player_pkg::FALL,
           player_pkg::POS_W, player_pkg::VEL_W;
#(
    parameter int TICK_DIV = 416667,
    parameter int STEP     = 5,
    parameter int X_MIN    = player_pkg::X_MIN,
    parameter int X_MAX    = player_pkg::X_MAX,
    parameter int X_RESET  = 300,
    parameter int Y_GROUND = player_pkg::Y_GROUND,
    parameter int JUMP_V0  = 12
) (
    input logic                 clk,
    input logic                 rst,
    player_motion_ctrl_if.slave bus
);

    localparam int SUM_W = POS_W + 1;

    logic [1:0]       r_sync_q, l_sync_q, j_sync_q;
    logic             j_prev_q, jump_pend_q, jump_pend_d;
    logic             r, l, j, j_rise, tick;
    state_t           state_q, state_d;
    logic [VEL_W-1:0] vel_q, vel_d;
    logic [POS_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic             jumping_q, move_tick_q;
    logic [SUM_W-1:0] x_sum, y_sum;
    logic [POS_W-1:0] x_right, x_left, y_fall;

    move_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .enable_i (bus.enable),
        .tick_o   (tick)
    );

    assign r = ~r_sync_q[1];
    assign l = ~l_sync_q[1];
    assign j = ~j_sync_q[1];
    assign j_rise = j & ~j_prev_q;
    // A press latched on a tick survives that tick so it is never silently dropped.
    assign jump_pend_d = j_rise | (jump_pend_q & ~tick);

    // Sums carry an extra bit so clamping never sees a wrapped value.
    assign x_sum   = {1'b0, pos_x_q} + SUM_W'(STEP);
    assign x_right = (x_sum > SUM_W'(X_MAX)) ? POS_W'(X_MAX) : x_sum[POS_W-1:0];
    assign x_left  = ({1'b0, pos_x_q} < SUM_W'(X_MIN + STEP)) ? POS_W'(X_MIN) : pos_x_q - POS_W'(STEP);
    assign y_sum   = {1'b0, pos_y_q} + SUM_W'(vel_q) + SUM_W'(1);
    assign y_fall  = (y_sum > SUM_W'(Y_GROUND)) ? POS_W'(Y_GROUND) : y_sum[POS_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) state_q <= GROUND;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                GROUND:  state_d = jump_pend_q ? RISE : GROUND;
                RISE:    state_d = (vel_q == VEL_W'(1)) ? FALL : RISE;
                FALL:    state_d = (y_fall == POS_W'(Y_GROUND)) ? GROUND : FALL;
                default: state_d = GROUND;
            endcase
        end
    end

    always_comb begin
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        vel_d   = vel_q;
        if (tick) begin
            pos_x_d = (r & ~l) ? x_right : (l & ~r) ? x_left : pos_x_q;
            case (state_q)
                GROUND: vel_d = jump_pend_q ? VEL_W'(JUMP_V0) : '0;
                RISE: begin
                    pos_y_d = pos_y_q - POS_W'(vel_q);
                    vel_d   = (vel_q == VEL_W'(1)) ? '0 : vel_q - VEL_W'(1);
                end
                FALL: begin
                    pos_y_d = y_fall;
                    vel_d   = (y_fall == POS_W'(Y_GROUND)) ? '0 : vel_q + VEL_W'(1);
                end
                default: vel_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_q    <= '1;
            l_sync_q    <= '1;
            j_sync_q    <= '1;
            j_prev_q    <= 1'b0;
            jump_pend_q <= 1'b0;
            vel_q       <= '0;
            pos_x_q     <= POS_W'(X_RESET);
            pos_y_q     <= POS_W'(Y_GROUND);
            jumping_q   <= 1'b0;
            move_tick_q <= 1'b0;
        end else begin
            r_sync_q    <= {r_sync_q[0], bus.right_n};
            l_sync_q    <= {l_sync_q[0], bus.left_n};
            j_sync_q    <= {j_sync_q[0], bus.jump_n};
            j_prev_q    <= j;
            jump_pend_q <= jump_pend_d;
            vel_q       <= vel_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            jumping_q   <= (state_d != GROUND);
            move_tick_q <= tick;
        end
    end

    assign bus.pos_x     = pos_x_q;
    assign bus.pos_y     = pos_y_q;
    assign bus.jumping   = jumping_q;
    assign bus.move_tick = move_tick_q;

endmodule
